arm_blk_xfer_seq: RTL

Multi-cycle sequencer for ARM block transfers (LDM/STM). It walks a 16-bit register list and issues one memory word access per listed register. For stores it reads each register through a read port of the banked register file. For loads it writes each word back through the register file write port, or the PC write port for r15. It also performs base-register writeback, and sits between decode/execute and the register file / data-memory interface.

---
 rtl/arm_blk_xfer_seq.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/arm_blk_xfer_seq.sv
// arm_blk_xfer_seq: LDM/STM block-transfer sequencer with base writeback
module arm_blk_xfer_seq #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              p_bit,
  input  logic              u_bit,
  input  logic              w_bit,
  input  logic [3:0]        base_reg,
  input  logic [ADDR_W-1:0] base_val,
  input  logic [15:0]       reg_list,
  output logic [3:0]        rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [3:0]        rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  output logic              rf_write_reg,
  output logic              rf_write_pc,
  output logic [DATA_W-1:0] pc_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, SETUP, XFER, WB, DONE} state_t;
  state_t state_q, state_d;
  logic is_load_q, is_load_d, p_q, p_d, u_q, u_d, wb_q, wb_d;
  logic [3:0] base_reg_q, base_reg_d, cur;
  logic [15:0] rem_q, rem_d;
  logic [ADDR_W-1:0] base_q, base_d, addr_q, addr_d, final_q, final_d, n4;
  logic [4:0] n;
  // state and latched-request registers; reset aborts any transfer at once
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      is_load_q  <= 1'b0;
      p_q        <= 1'b0;
      u_q        <= 1'b0;
      wb_q       <= 1'b0;
      base_reg_q <= '0;
      rem_q      <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      final_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_load_q  <= is_load_d;
      p_q        <= p_d;
      u_q        <= u_d;
      wb_q       <= wb_d;
      base_reg_q <= base_reg_d;
      rem_q      <= rem_d;
      base_q     <= base_d;
      addr_q     <= addr_d;
      final_q    <= final_d;
    end
  end
  // next state, address arithmetic and per-state interface outputs
  always_comb begin
    state_d      = state_q;
    is_load_d    = is_load_q;
    p_d          = p_q;
    u_d          = u_q;
    wb_d         = wb_q;
    base_reg_d   = base_reg_q;
    rem_d        = rem_q;
    base_d       = base_q;
    addr_d       = addr_q;
    final_d      = final_q;
    rf_rd_addr   = '0;
    rf_w_addr    = '0;
    rf_w_data    = '0;
    rf_write_reg = 1'b0;
    rf_write_pc  = 1'b0;
    pc_data      = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    done         = 1'b0;
    n            = '0;
    cur          = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(rem_q[i]);
    for (int i = 15; i >= 0; i--) if (rem_q[i]) cur = 4'(i);
    n4   = ADDR_W'({n, 2'b00});
    busy = (state_q == SETUP) || (state_q == XFER) || (state_q == WB);
    case (state_q)
      IDLE: if (start) begin
        is_load_d  = is_load;
        p_d        = p_bit;
        u_d        = u_bit;
        wb_d       = w_bit && (base_reg != 4'd15) && !(is_load && reg_list[base_reg]);
        base_reg_d = base_reg;
        base_d     = base_val;
        rem_d      = reg_list;
        state_d    = SETUP;
      end
      SETUP: begin
        final_d = u_q ? base_q + n4 : base_q - n4;
        addr_d  = u_q ? (p_q ? base_q + ADDR_W'(4) : base_q)
                      : (p_q ? base_q - n4 : base_q - n4 + ADDR_W'(4));
        state_d = (n == 5'd0) ? DONE : XFER;
      end
      XFER: begin
        mem_req    = 1'b1;
        mem_we     = !is_load_q;
        mem_addr   = addr_q;
        rf_rd_addr = is_load_q ? 4'd0 : cur;
        mem_wdata  = is_load_q ? '0 : rf_rd_data;
        if (mem_ready) begin
          addr_d       = addr_q + ADDR_W'(4);
          rem_d        = rem_q & (rem_q - 16'd1);
          rf_write_reg = is_load_q && (cur != 4'd15);
          rf_write_pc  = is_load_q && (cur == 4'd15);
          rf_w_addr    = rf_write_reg ? cur : 4'd0;
          rf_w_data    = rf_write_reg ? mem_rdata : '0;
          pc_data      = rf_write_pc ? mem_rdata : '0;
          state_d      = (rem_d != 16'd0) ? XFER : (wb_q ? WB : DONE);
        end
      end
      WB: begin
        rf_write_reg = 1'b1;
        rf_w_addr    = base_reg_q;
        rf_w_data    = DATA_W'(final_q);
        state_d      = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule
